alu_arbiter: RTL and testbench

- Shares one combinational 4-bit ALU (add/sub/mul/div, 2-bit command, 8-bit result) between two requesters.
- Round-robin arbitration with a req/done handshake per requester.
- Drives the ALU operand and command inputs from registers, waits a programmable settle time, then captures the ALU result into a registered output.
- Sits between two client FSMs and the ALU instance.

---
 rtl/alu_arbiter_if.sv | 61 ++++++
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundles every signal between the alu_arbiter, its two client FSMs and the
// shared combinational ALU.
//
// Handshake (both requesters): a client raises reqN with aN/bN/cmdN valid and
// keeps req high until it sees doneN. doneN is a one-cycle pulse. The client
// drops req on the clock edge that ends the done cycle. req is only sampled
// while the arbiter is idle. Operands only need to be stable on the edge that
// samples the request. result/err are qualified by done0/done1.
//
// Signals:
//   req0/a0/b0/cmd0   requester 0 request, operands and command
//   req1/a1/b1/cmd1   requester 1 request, operands and command
//   alu_a/alu_b/alu_cmd  registered operands/command driven to the ALU
//   alu_result        combinational ALU result
//   result            captured result, held until the next capture
//   done0/done1       completion pulses, one per requester
//   err               error qualifier, valid with done0/done1
//   busy              operation in flight
//
// Modports:
//   slave  - arbiter side
//   master - client/ALU side (drives requests and alu_result)
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic [1:0] cmd0;
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [1:0] cmd1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_cmd;
  logic [7:0] alu_result;
  logic [7:0] result;
  logic       done0;
  logic       done1;
  logic       err;
  logic       busy;

  modport slave (
    input  req0, a0, b0, cmd0,
    input  req1, a1, b1, cmd1,
    input  alu_result,
    output alu_a, alu_b, alu_cmd,
    output result, done0, done1, err, busy
  );

  modport master (
    output req0, a0, b0, cmd0,
    output req1, a1, b1, cmd1,
    output alu_result,
    input  alu_a, alu_b, alu_cmd,
    input  result, done0, done1, err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational 4-bit ALU between two requesters. A round-robin
// grant is made in IDLE, the grantee's operands/command are registered onto
// the ALU inputs, the ALU is given SETTLE cycles in EXEC, then its result is
// captured and the grantee gets a one-cycle done pulse in DONE.
//
// Parameters:
//   SETTLE  cycles spent in EXEC before capturing alu_result (1..15)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        alu_arbiter_if.slave (requests, ALU drive, results)
//   dbg_state  current FSM state (0 IDLE, 1 EXEC, 2 DONE)
//
// Optional feature (macro DIV0_GUARD_EN):
//   When defined, a granted divide (cmd 11) with b == 0 skips EXEC and
//   completes on the grant edge with result 8'hFF and err = 1. When not
//   defined, divide-by-zero goes to the ALU like any other command and err is
//   tied low.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("alu_arbiter: SETTLE must be in 1..15");
  end

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic       gnt_q, gnt_n;       // requester owning the in-flight operation
  logic       last_q, last_n;     // requester granted most recently
  logic [3:0] alu_a_q, alu_a_n;
  logic [3:0] alu_b_q, alu_b_n;
  logic [1:0] alu_cmd_q, alu_cmd_n;
  logic [7:0] result_q, result_n;
  logic       done0_q, done0_n;
  logic       done1_q, done1_n;
`ifdef DIV0_GUARD_EN
  logic       err_q, err_n;
  logic       pick_div0;
`endif

  // Grant selection: a lone request wins outright; on a tie the requester
  // that was not granted last wins.
  logic       any_req;
  logic       pick;
  logic [3:0] pick_a;
  logic [3:0] pick_b;
  logic [1:0] pick_cmd;

  assign any_req  = bus.req0 | bus.req1;
  assign pick     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
  assign pick_a   = pick ? bus.a1   : bus.a0;
  assign pick_b   = pick ? bus.b1   : bus.b0;
  assign pick_cmd = pick ? bus.cmd1 : bus.cmd0;

`ifdef DIV0_GUARD_EN
  assign pick_div0 = (pick_cmd == 2'b11) && (pick_b == 4'd0);
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    gnt_n     = gnt_q;
    last_n    = last_q;
    alu_a_n   = alu_a_q;
    alu_b_n   = alu_b_q;
    alu_cmd_n = alu_cmd_q;
    result_n  = result_q;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
`ifdef DIV0_GUARD_EN
    err_n     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          alu_a_n   = pick_a;
          alu_b_n   = pick_b;
          alu_cmd_n = pick_cmd;
          gnt_n     = pick;
          cnt_n     = SETTLE_M1;
`ifdef DIV0_GUARD_EN
          if (pick_div0) begin
            // Complete immediately; the ALU is never consulted.
            state_n  = S_DONE;
            result_n = 8'hFF;
            err_n    = 1'b1;
            done0_n  = ~pick;
            done1_n  = pick;
          end else begin
            state_n  = S_EXEC;
          end
`else
          state_n = S_EXEC;
`endif
        end
      end

      S_EXEC: begin
        // The counter is loaded with SETTLE-1 on grant, so EXEC spans
        // exactly SETTLE cycles before the capture edge.
        if (cnt_q == 4'd0) begin
          result_n = bus.alu_result;
          state_n  = S_DONE;
          done0_n  = ~gnt_q;
          done1_n  = gnt_q;
        end else begin
          cnt_n = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        last_n  = gnt_q;
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;   // requester 0 wins the first tie
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_cmd_q <= 2'd0;
      result_q  <= 8'd0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
`ifdef DIV0_GUARD_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      gnt_q     <= gnt_n;
      last_q    <= last_n;
      alu_a_q   <= alu_a_n;
      alu_b_q   <= alu_b_n;
      alu_cmd_q <= alu_cmd_n;
      result_q  <= result_n;
      done0_q   <= done0_n;
      done1_q   <= done1_n;
`ifdef DIV0_GUARD_EN
      err_q     <= err_n;
`endif
    end
  end

  assign bus.alu_a   = alu_a_q;
  assign bus.alu_b   = alu_b_q;
  assign bus.alu_cmd = alu_cmd_q;
  assign bus.result  = result_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.busy    = (state_q != S_IDLE);
`ifdef DIV0_GUARD_EN
  assign bus.err     = err_q;
`else
  assign bus.err     = 1'b0;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Two arbiter instances (SETTLE=1 main, SETTLE=4 secondary), each driving a
// behavioural ALU. Completed operations on the main instance are compared
// against an expected queue filled by a transaction-level round-robin model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int unsigned SETTLE  = 1;
  localparam int unsigned SETTLE4 = 4;
`ifdef DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;
  int         cyc;
  int         checks;
  int         failures;
  logic [9:0] exp_q[$];     // {id, err, result}
  int         last_model;   // requester granted last, per the model
  int         done_cyc[2];
  int         done_seen;
  bit         prev_d0;
  bit         prev_d1;

  alu_arbiter_if bus();
  alu_arbiter_if bus4();

  alu_arbiter #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );
  alu_arbiter #(.SETTLE(SETTLE4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(dbg_state4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU and spec model ----------------
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] cmd);
    logic [7:0] wa;
    logic [7:0] wb;
    wa = {4'd0, a};
    wb = {4'd0, b};
    case (cmd)
      2'b00:   return wa + wb;
      2'b01:   return wa - wb;
      2'b10:   return wa * wb;
      default: return (b == 4'd0) ? 8'h00 : wa / wb;
    endcase
  endfunction

  function automatic logic [8:0] spec_out(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] cmd);
    if (GUARD && cmd == 2'b11 && b == 4'd0) return {1'b1, 8'hFF};
    return {1'b0, alu_model(a, b, cmd)};
  endfunction

  assign bus.alu_result  = alu_model(bus.alu_a, bus.alu_b, bus.alu_cmd);
  assign bus4.alu_result = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_cmd);

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor (main DUT) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.busy) check("idle_quiet", 32'({bus.done0, bus.done1, bus.err}), 32'd0);
      if (bus.done0 || bus.done1) begin
        done_seen++;
        check("done_onehot", 32'(bus.done0 & bus.done1), 32'd0);
        check("done_width", 32'({prev_d0 & bus.done0, prev_d1 & bus.done1}), 32'd0);
        if (bus.done0) done_cyc[0] = cyc;
        if (bus.done1) done_cyc[1] = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got id=%0d result=%0h required no done (t=%0t)",
                   bus.done1, bus.result, $time);
        end else begin
          check("done_id_err_result", 32'({bus.done1, bus.err, bus.result}),
                32'(exp_q.pop_front()));
        end
      end
      prev_d0 = bus.done0;
      prev_d1 = bus.done1;
    end else begin
      prev_d0 = 1'b0;
      prev_d1 = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_op(input int id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] cmd);
    exp_q.push_back({id[0], spec_out(a, b, cmd)});
    last_model = id;
  endtask

  // One client transaction: raise req, wait for done, drop req on the edge
  // ending the done cycle. lat counts edges from the sampling edge to done.
  task automatic client(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] cmd, input bit scramble,
                        output int lat, output int busy_cnt);
    bit got;
    lat = 0;
    busy_cnt = 0;
    got = 1'b0;
    @(negedge clk);
    if (id == 0) begin
      bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.cmd0 = cmd;
    end else begin
      bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.cmd1 = cmd;
    end
    @(posedge clk);
    #1;
    if (scramble) begin
      if (id == 0) begin
        bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.cmd0 = 2'($urandom);
      end else begin
        bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.cmd1 = 2'($urandom);
      end
    end
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_cnt++;
      got = (id == 0) ? bus.done0 : bus.done1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout id=%0d got no done required done within 200 cycles", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic single_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] cmd, input logic [7:0] er, input bit ee);
    int lat, bc, exp_lat;
    exp_q.push_back({id, ee, er});
    last_model = int'(id);
    exp_lat = (GUARD && cmd == 2'b11 && b == 4'd0) ? 1 : int'(SETTLE) + 1;
    client(int'(id), a, b, cmd, 1'b1, lat, bc);
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(bc), 32'(exp_lat));
  endtask

  // Both active requesters raise req on the same edge.
  task automatic run_round(input bit act0, input bit act1,
                           input logic [3:0] a0v, input logic [3:0] b0v, input logic [1:0] c0v,
                           input logic [3:0] a1v, input logic [3:0] b1v, input logic [1:0] c1v);
    int l0, l1, k0, k1;
    if (act0 && act1) begin
      if (last_model == 0) begin
        expect_op(1, a1v, b1v, c1v); expect_op(0, a0v, b0v, c0v);
      end else begin
        expect_op(0, a0v, b0v, c0v); expect_op(1, a1v, b1v, c1v);
      end
    end else if (act0) begin
      expect_op(0, a0v, b0v, c0v);
    end else if (act1) begin
      expect_op(1, a1v, b1v, c1v);
    end
    fork
      begin if (act0) client(0, a0v, b0v, c0v, 1'b0, l0, k0); end
      begin if (act1) client(1, a1v, b1v, c1v, 1'b0, l1, k1); end
    join
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] cmd;
    logic [7:0] exp_result;
    bit         exp_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [3:0] ra[2][3];
    logic [3:0] rb[2][3];
    logic [1:0] rc[2][3];
    int seen_before;

    vecs[0] = '{1'b0, 4'd3,  4'd4,  2'b00, 8'h07, 1'b0};
    vecs[1] = '{1'b1, 4'd2,  4'd5,  2'b01, 8'hFD, 1'b0};
    vecs[2] = '{1'b0, 4'd5,  4'd6,  2'b10, 8'h1E, 1'b0};
    vecs[3] = '{1'b1, 4'd9,  4'd2,  2'b01, 8'h07, 1'b0};
    vecs[4] = '{1'b0, 4'd15, 4'd15, 2'b10, 8'hE1, 1'b0};
    vecs[5] = '{1'b1, 4'd15, 4'd4,  2'b11, 8'h03, 1'b0};
    vecs[6] = '{1'b0, 4'd15, 4'd15, 2'b00, 8'h1E, 1'b0};
    vecs[7] = '{1'b1, 4'd0,  4'd0,  2'b00, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 4'd7,  4'd0,  2'b11, GUARD ? 8'hFF : 8'h00, GUARD};
    vecs[9] = '{1'b1, 4'd14, 4'd3,  2'b11, 8'h04, 1'b0};

    checks = 0; failures = 0; last_model = 1; done_seen = 0;
    prev_d0 = 1'b0; prev_d1 = 1'b0;
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.cmd0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.cmd1 = '0;
    bus4.req0 = 1'b0; bus4.a0 = '0; bus4.b0 = '0; bus4.cmd0 = '0;
    bus4.req1 = 1'b0; bus4.a1 = '0; bus4.b1 = '0; bus4.cmd1 = '0;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cmd}), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'({bus.done0, bus.done1, bus.err, bus.busy}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests right after reset: requester 0 wins the tie
    run_round(1'b1, 1'b1, 4'd5, 4'd6, 2'b10, 4'd9, 4'd2, 2'b01);
    check("tie_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(SETTLE + 2));

    // Table of single operations
    for (int i = 0; i < 10; i++)
      single_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cmd, vecs[i].exp_result,
                vecs[i].exp_err);

    // Both requesters continuously active for six operations
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 3; j++) begin
        ra[r][j] = 4'($urandom); rb[r][j] = 4'($urandom); rc[r][j] = 2'($urandom);
      end
    first = (last_model == 0) ? 1 : 0;
    for (int k = 0; k < 6; k++) begin
      int id;
      id = (k % 2 == 0) ? first : 1 - first;
      expect_op(id, ra[id][k/2], rb[id][k/2], rc[id][k/2]);
    end
    fork
      begin
        int l, bc;
        for (int j = 0; j < 3; j++) client(0, ra[0][j], rb[0][j], rc[0][j], 1'b0, l, bc);
      end
      begin
        int l, bc;
        for (int j = 0; j < 3; j++) client(1, ra[1][j], rb[1][j], rc[1][j], 1'b0, l, bc);
      end
    join

    // Randomized rounds
    for (int n = 0; n < 24; n++) begin
      int mode;
      logic [3:0] x0, y0, x1, y1;
      logic [1:0] c0, c1;
      mode = $urandom_range(1, 3);
      x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15)); c0 = 2'($urandom_range(0, 3));
      x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15)); c1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin y0 = 4'd0; c0 = 2'b11; end
      if ($urandom_range(0, 5) == 0) begin y1 = 4'd0; c1 = 2'b11; end
      run_round(mode[0], mode[1], x0, y0, c0, x1, y1, c1);
    end

    // Reset during EXEC discards the operation
    @(negedge clk);
    bus.req0 = 1'b1; bus.a0 = 4'd6; bus.b0 = 4'd7; bus.cmd0 = 2'b10;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_cmd}), 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_flags", 32'({bus.done0, bus.done1, bus.err, bus.busy}), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    bus.req0 = 1'b0;
    seen_before = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (SETTLE + 4) @(negedge clk);
    check("no_done_after_reset", 32'(done_seen - seen_before), 32'd0);
    last_model = 1;
    single_op(1'b0, 4'd6, 4'd7, 2'b10, 8'h2A, 1'b0);

    // SETTLE=4 instance: operands stable through EXEC, done on the fifth edge
    @(negedge clk);
    bus4.req1 = 1'b1; bus4.a1 = 4'd15; bus4.b1 = 4'd15; bus4.cmd1 = 2'b10;
    @(posedge clk);
    #1;
    bus4.a1 = 4'd1; bus4.b1 = 4'd2; bus4.cmd1 = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_exec_alu", 32'({bus4.alu_a, bus4.alu_b, bus4.alu_cmd}),
            32'({4'hF, 4'hF, 2'b10}));
      check("s4_exec_flags", 32'({bus4.busy, bus4.done0, bus4.done1}), 32'b100);
    end
    @(negedge clk);
    check("s4_done", 32'({bus4.done1, bus4.done0, bus4.err, bus4.result}),
          32'({1'b1, 1'b0, 1'b0, 8'hE1}));
    @(posedge clk);
    #1 bus4.req1 = 1'b0;
    @(negedge clk);
    check("s4_idle", 32'({bus4.busy, bus4.done1, bus4.done0}), 32'd0);
    check("s4_result_hold", 32'(bus4.result), 32'hE1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
